// File: rtl/truth_table_sequencer_if.sv
// Host-side control/status bundle for truth_table_sequencer.
// The master issues sweep requests; the slave (the sequencer) reports the verdict.
interface truth_table_sequencer_if;
    logic        start;
    logic        busy;
    logic        done;
    logic        pass;
    logic [4:0]  mismatch_count;
    logic [3:0]  first_fail_idx;
    logic [15:0] resp;

    modport master (
        output start,
        input  busy,
        input  done,
        input  pass,
        input  mismatch_count,
        input  first_fail_idx,
        input  resp
    );

    modport slave (
        input  start,
        output busy,
        output done,
        output pass,
        output mismatch_count,
        output first_fail_idx,
        output resp
    );
endinterface

// File: rtl/truth_table_sequencer.sv
// Sweeps a 4-input logic circuit through all 16 vectors and grades its synchronized output against TT.
// Optional macro TRUTH_TABLE_STABILITY_CHECK_EN also fails vectors whose output moves late in the settle window.
//
// state | meaning
// IDLE  | in* held at 0, waiting for start
// RUN   | driving vector idx, counting settle cycles, sampling at the last one
// DONE  | sweep complete; done/pass are published on the exit edge
module truth_table_sequencer #(
    parameter logic [15:0] TT         = 16'h3812,
    parameter int unsigned SETTLE     = 4,
    parameter int unsigned STABLE_WIN = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    truth_table_sequencer_if.slave      host,
    input  logic                        dut_out,
    output logic                        in1,
    output logic                        in2,
    output logic                        in3,
    output logic                        in4
);

    localparam int unsigned CNT_W = $clog2(SETTLE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

    generate
        if (SETTLE < 3) begin : g_bad_settle
            $error("SETTLE must be at least 3 (two synchronizer stages plus one)");
        end
`ifdef TRUTH_TABLE_STABILITY_CHECK_EN
        if (STABLE_WIN < 1 || STABLE_WIN > SETTLE - 2) begin : g_bad_win
            $error("STABLE_WIN must lie in 1..SETTLE-2");
        end
`else
        if (STABLE_WIN == 0) begin : g_bad_win
            $error("STABLE_WIN must be at least 1");
        end
`endif
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              sync1_q, sync2_q;
    logic [15:0]       resp_q, resp_d;
    logic [4:0]        mm_q, mm_d;
    logic [3:0]        first_q, first_d;
    logic              pass_q, pass_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic [3:0]        in_q, in_d;
    logic              vec_fail;

`ifdef TRUTH_TABLE_STABILITY_CHECK_EN
    localparam logic [CNT_W-1:0] WIN_START = CNT_W'(SETTLE - STABLE_WIN);

    logic sync_prev_q;
    logic unstable_q;
    logic win_change;

    // A change only counts when both the previous and current cycle lie inside the window.
    always_comb begin
        win_change = 1'b0;
        if ((cnt_q > WIN_START) && (sync2_q != sync_prev_q)) begin
            win_change = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_prev_q <= 1'b0;
            unstable_q  <= 1'b0;
        end else begin
            sync_prev_q <= sync2_q;
            if ((state_q != RUN) || (cnt_q == CNT_LAST)) begin
                unstable_q <= 1'b0;
            end else if (win_change) begin
                unstable_q <= 1'b1;
            end
        end
    end

    assign vec_fail = (sync2_q != TT[idx_q]) | unstable_q | win_change;
`else
    assign vec_fail = (sync2_q != TT[idx_q]);
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        resp_d  = resp_q;
        mm_d    = mm_q;
        first_d = first_q;
        pass_d  = pass_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (host.start) begin
                    state_d = RUN;
                    idx_d   = 4'd0;
                    cnt_d   = '0;
                    resp_d  = 16'h0000;
                    mm_d    = 5'd0;
                    first_d = 4'd0;
                    pass_d  = 1'b0;
                end
            end
            RUN: begin
                if (cnt_q == CNT_LAST) begin
                    resp_d[idx_q] = sync2_q;
                    if (vec_fail) begin
                        mm_d = mm_q + 5'd1;
                        if (mm_q == 5'd0) begin
                            first_d = idx_q;
                        end
                    end
                    if (idx_q == 4'd15) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + 4'd1;
                        cnt_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                done_d  = 1'b1;
                pass_d  = (mm_q == 5'd0);
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Circuit inputs register together with idx so the settle window starts on the same edge.
        busy_d = (state_d == RUN);
        in_d   = (state_d == RUN) ? idx_d : 4'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= 4'd0;
            cnt_q   <= '0;
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            resp_q  <= 16'h0000;
            mm_q    <= 5'd0;
            first_q <= 4'd0;
            pass_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            in_q    <= 4'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            sync1_q <= dut_out;
            sync2_q <= sync1_q;
            resp_q  <= resp_d;
            mm_q    <= mm_d;
            first_q <= first_d;
            pass_q  <= pass_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            in_q    <= in_d;
        end
    end

    assign {in1, in2, in3, in4} = in_q;

    assign host.busy           = busy_q;
    assign host.done           = done_q;
    assign host.pass           = pass_q;
    assign host.mismatch_count = mm_q;
    assign host.first_fail_idx = first_q;
    assign host.resp           = resp_q;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Bench for truth_table_sequencer: two instances (SETTLE=4 and SETTLE=6) driven by a delayed circuit model,
// graded against a timeline model of what the sampler should see.
module tb_truth_table_sequencer;
    localparam logic [15:0] TT_EXP = 16'h3812;
    localparam int S_A = 4;
    localparam int S_B = 6;
    localparam int WIN = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic dut_out_a = 1'b0;
    logic dut_out_b = 1'b0;
    logic [3:0] in_a;
    logic [3:0] in_b;

    truth_table_sequencer_if h_a ();
    truth_table_sequencer_if h_b ();

    int errs = 0;
    int checks = 0;

    logic [15:0] f_fn [2];
    int          dly [2];
    int          glitch_t [2];
    int          tcyc [2];
    logic [3:0]  hist [2][8];

    always #5 clk = ~clk;

    truth_table_sequencer #(.TT(16'h3812), .SETTLE(S_A), .STABLE_WIN(WIN)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .host(h_a), .dut_out(dut_out_a),
        .in1(in_a[3]), .in2(in_a[2]), .in3(in_a[1]), .in4(in_a[0])
    );

    truth_table_sequencer #(.TT(16'h3812), .SETTLE(S_B), .STABLE_WIN(WIN)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .host(h_b), .dut_out(dut_out_b),
        .in1(in_b[3]), .in2(in_b[2]), .in3(in_b[1]), .in4(in_b[0])
    );

    // Circuit model: out = f[input d cycles ago], optionally inverted for one cycle at tcyc == glitch_t.
    always @(posedge clk) begin
        logic [3:0] v;
        #1;
        for (int u = 0; u < 2; u++) begin
            for (int j = 7; j > 0; j--) hist[u][j] = hist[u][j-1];
            hist[u][0] = (u == 0) ? in_a : in_b;
            tcyc[u] = tcyc[u] + 1;
        end
        v = hist[0][dly[0]];
        dut_out_a = f_fn[0][v] ^ ((tcyc[0] == glitch_t[0]) ? 1'b1 : 1'b0);
        v = hist[1][dly[1]];
        dut_out_b = f_fn[1][v] ^ ((tcyc[1] == glitch_t[1]) ? 1'b1 : 1'b0);
    end

    // Vector applied t cycles after the start-accepting edge; 0 outside the sweep.
    function automatic int in_at(input int t, input int s);
        return (t >= 0 && t < 16 * s) ? t / s : 0;
    endfunction

    function automatic logic out_at(input logic [15:0] f, input int d, input int g, input int s, input int t);
        logic [3:0] v;
        v = 4'(in_at(t - d, s));
        return f[v] ^ ((t == g) ? 1'b1 : 1'b0);
    endfunction

    // The grader sees the circuit output from two cycles before its sampling edge.
    task automatic model(input logic [15:0] f, input int d, input int g, input int s,
                         output logic [15:0] e_resp, output int e_cnt, output int e_first);
        logic [15:0] tt;
        logic smp;
        logic bad;
        tt = TT_EXP;
        e_resp = 16'h0000;
        e_cnt = 0;
        e_first = 0;
        for (int k = 0; k < 16; k++) begin
            smp = out_at(f, d, g, s, k * s + s - 3);
            bad = (smp != tt[k]);
`ifdef TRUTH_TABLE_STABILITY_CHECK_EN
            for (int t = k * s + s - WIN - 2; t < k * s + s - 3; t++)
                if (out_at(f, d, g, s, t) != out_at(f, d, g, s, t + 1)) bad = 1'b1;
`endif
            e_resp[k] = smp;
            if (bad) begin
                if (e_cnt == 0) e_first = k;
                e_cnt++;
            end
        end
    endtask

    task automatic sample(input int u, output logic [3:0] iv, output logic bsy, output logic dn,
                          output logic ps, output logic [4:0] mc, output logic [3:0] ff, output logic [15:0] rs);
        if (u == 0) begin
            iv = in_a; bsy = h_a.busy; dn = h_a.done; ps = h_a.pass;
            mc = h_a.mismatch_count; ff = h_a.first_fail_idx; rs = h_a.resp;
        end else begin
            iv = in_b; bsy = h_b.busy; dn = h_b.done; ps = h_b.pass;
            mc = h_b.mismatch_count; ff = h_b.first_fail_idx; rs = h_b.resp;
        end
    endtask

    task automatic set_start(input int u, input logic v);
        if (u == 0) h_a.start = v;
        else        h_b.start = v;
    endtask

    task automatic run_sweep(input string tag, input int u, input logic [15:0] f, input int d,
                             input int g, input int pulse_at);
        int s;
        int n;
        int done_at;
        logic [3:0] iv; logic bsy, dn, ps; logic [4:0] mc; logic [3:0] ff; logic [15:0] rs;
        logic [15:0] e_resp; int e_cnt, e_first;
        s = (u == 0) ? S_A : S_B;
        tcyc[u] = -100;
        f_fn[u] = f; dly[u] = d; glitch_t[u] = g;
        model(f, d, g, s, e_resp, e_cnt, e_first);
        repeat (6) @(negedge clk);
        set_start(u, 1'b1);
        tcyc[u] = -1;
        @(negedge clk);
        set_start(u, 1'b0);
        n = 0;
        done_at = -1;
        while (done_at < 0 && n < 16 * s + 20) begin
            sample(u, iv, bsy, dn, ps, mc, ff, rs);
            if (dn) done_at = n;
            else begin
                checks++;
                if (iv !== 4'(in_at(n, s))) begin
                    errs++; $display("FAIL %s vector n=%0d: got %0d want %0d", tag, n, iv, in_at(n, s));
                end
                checks++;
                if (bsy !== ((n < 16 * s) ? 1'b1 : 1'b0)) begin
                    errs++; $display("FAIL %s busy n=%0d: got %0b", tag, n, bsy);
                end
            end
            if (done_at < 0) begin
                set_start(u, (n == pulse_at) ? 1'b1 : 1'b0);
                @(negedge clk);
                n++;
            end
        end
        set_start(u, 1'b0);
        checks++;
        if (done_at != 16 * s + 1) begin
            errs++; $display("FAIL %s done_cycle: got %0d want %0d", tag, done_at, 16 * s + 1);
        end
        checks++;
        if (mc !== 5'(e_cnt)) begin
            errs++; $display("FAIL %s mismatch_count: got %0d want %0d", tag, mc, e_cnt);
        end
        checks++;
        if (ff !== 4'(e_first)) begin
            errs++; $display("FAIL %s first_fail_idx: got %0d want %0d", tag, ff, e_first);
        end
        checks++;
        if (rs !== e_resp) begin
            errs++; $display("FAIL %s resp: got %h want %h", tag, rs, e_resp);
        end
        checks++;
        if (ps !== ((e_cnt == 0) ? 1'b1 : 1'b0)) begin
            errs++; $display("FAIL %s pass: got %0b want %0b", tag, ps, (e_cnt == 0));
        end
        @(negedge clk);
        sample(u, iv, bsy, dn, ps, mc, ff, rs);
        checks++;
        if (dn !== 1'b0) begin
            errs++; $display("FAIL %s done_width: got %0b want 0", tag, dn);
        end
        checks++;
        if (ps !== ((e_cnt == 0) ? 1'b1 : 1'b0)) begin
            errs++; $display("FAIL %s pass_hold: got %0b want %0b", tag, ps, (e_cnt == 0));
        end
    endtask

    task automatic test_reset();
        logic [3:0] iv; logic bsy, dn, ps; logic [4:0] mc; logic [3:0] ff; logic [15:0] rs;
        repeat (3) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            sample(u, iv, bsy, dn, ps, mc, ff, rs);
            checks++;
            if ({iv, bsy, dn, ps, mc, ff, rs} !== 31'd0) begin
                errs++; $display("FAIL reset_outputs u=%0d: in=%0d busy=%0b done=%0b pass=%0b mc=%0d ff=%0d resp=%h want all 0",
                                 u, iv, bsy, dn, ps, mc, ff, rs);
            end
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        sample(0, iv, bsy, dn, ps, mc, ff, rs);
        checks++;
        if ({iv, bsy, dn} !== 6'd0) begin
            errs++; $display("FAIL idle_after_reset: in=%0d busy=%0b done=%0b want 0", iv, bsy, dn);
        end
    endtask

    task automatic test_ideal();
        run_sweep("ideal", 0, TT_EXP, 0, -1000, -1);
    endtask

    task automatic test_stuck();
        run_sweep("stuck0", 0, 16'h0000, 0, -1000, -1);
        run_sweep("stuck1", 0, 16'hFFFF, 0, -1000, -1);
    endtask

    task automatic test_delay();
        run_sweep("delay3_s4", 0, TT_EXP, 3, -1000, -1);
        run_sweep("delay3_s6", 1, TT_EXP, 3, -1000, -1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            logic [15:0] f;
            int d;
            int u;
            f = 16'($urandom);
            d = int'($urandom_range(0, 3));
            u = int'($urandom_range(0, 1));
            run_sweep($sformatf("random%0d", i), u, f, d, -1000, -1);
        end
    endtask

    task automatic test_glitch();
        // Output of vector 4 is inverted for the first of its two windowed samples only.
        run_sweep("glitch_v4", 0, TT_EXP, 0, 16, -1);
    endtask

    task automatic test_start_while_busy();
        run_sweep("start_busy", 0, TT_EXP, 0, -1000, 20);
    endtask

    task automatic test_mid_reset();
        logic [3:0] iv; logic bsy, dn, ps; logic [4:0] mc; logic [3:0] ff; logic [15:0] rs;
        tcyc[0] = -100;
        f_fn[0] = 16'h3810; dly[0] = 0; glitch_t[0] = -1000;
        repeat (6) @(negedge clk);
        set_start(0, 1'b1);
        @(negedge clk);
        set_start(0, 1'b0);
        repeat (29) @(negedge clk);
        sample(0, iv, bsy, dn, ps, mc, ff, rs);
        checks++;
        if (iv !== 4'd7 || mc !== 5'd1 || rs !== 16'h0010) begin
            errs++; $display("FAIL pre_reset_state: in=%0d mc=%0d resp=%h want 7/1/0010", iv, mc, rs);
        end
        #2 rst_n = 1'b0;
        #1;
        sample(0, iv, bsy, dn, ps, mc, ff, rs);
        checks++;
        if ({iv, bsy, dn, ps, mc, ff, rs} !== 31'd0) begin
            errs++; $display("FAIL mid_reset_outputs: in=%0d busy=%0b done=%0b pass=%0b mc=%0d ff=%0d resp=%h want all 0",
                             iv, bsy, dn, ps, mc, ff, rs);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            sample(0, iv, bsy, dn, ps, mc, ff, rs);
            if (dn !== 1'b0 || bsy !== 1'b0) begin
                checks++; errs++;
                $display("FAIL no_done_after_abort: done=%0b busy=%0b at cycle %0d", dn, bsy, i);
            end
        end
        checks++;
        if (dn !== 1'b0 || bsy !== 1'b0) begin
            errs++; $display("FAIL idle_after_abort: done=%0b busy=%0b", dn, bsy);
        end
        run_sweep("post_reset", 0, TT_EXP, 0, -1000, -1);
    endtask

    task automatic test_back_to_back();
        logic [3:0] iv; logic bsy, dn, ps; logic [4:0] mc; logic [3:0] ff; logic [15:0] rs;
        int n, d1, d2;
        tcyc[0] = -100;
        f_fn[0] = TT_EXP; dly[0] = 0; glitch_t[0] = -1000;
        repeat (6) @(negedge clk);
        set_start(0, 1'b1);
        n = -1; d1 = -1; d2 = -1;
        while (d2 < 0 && n < 400) begin
            @(negedge clk);
            n++;
            sample(0, iv, bsy, dn, ps, mc, ff, rs);
            if (dn) begin
                if (d1 < 0) d1 = n;
                else d2 = n;
                checks++;
                if (ps !== 1'b1 || rs !== TT_EXP) begin
                    errs++; $display("FAIL b2b_result n=%0d: pass=%0b resp=%h want 1/%h", n, ps, rs, TT_EXP);
                end
            end
        end
        set_start(0, 1'b0);
        checks++;
        if (d1 != 16 * S_A + 1) begin
            errs++; $display("FAIL b2b_first_done: got %0d want %0d", d1, 16 * S_A + 1);
        end
        checks++;
        if (d2 - d1 != 16 * S_A + 2 || d2 < 0) begin
            errs++; $display("FAIL b2b_done_spacing: got %0d want %0d", d2 - d1, 16 * S_A + 2);
        end
        repeat (4) @(negedge clk);
    endtask

    initial begin
        h_a.start = 1'b0;
        h_b.start = 1'b0;
        for (int u = 0; u < 2; u++) begin
            f_fn[u] = TT_EXP;
            dly[u] = 0;
            glitch_t[u] = -1000;
            tcyc[u] = -100;
            for (int j = 0; j < 8; j++) hist[u][j] = 4'd0;
        end
        test_reset();
        test_ideal();
        test_stuck();
        test_delay();
        test_glitch();
        test_start_while_busy();
        test_mid_reset();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/truth_table_sequencer.md
Name: truth_table_sequencer

Overview:
- Upstream/downstream harness stage for a 4-input synthesized NOR/NOT logic circuit. The default target function is truth table 0x3812.
- Drives in1..in4 through all 16 input combinations in order.
- Waits a programmable settle window for the circuit's combinational/biological response, then samples its single output through a 2-flop synchronizer.
- Compares each sample against the expected truth table and reports pass/fail, mismatch count, first failing index and the captured response word.

Parameters:
- TT, 16'h3812, expected truth table; bit i = expected out for input index i.
- SETTLE, 4, cycles each vector is held; minimum 3 (2 sync stages + 1). Values <3 are illegal: elaboration error.
- STABLE_WIN, 2, trailing cycles of the settle window checked for stability (optional feature only); 1 <= STABLE_WIN <= SETTLE-2.

Ports:
- clk  input  1  single clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a 16-vector sweep; sampled in IDLE only.
- dut_out  input  1  circuit output; asynchronous, synchronized internally.
- in1  output  1  circuit input, index bit 3.
- in2  output  1  circuit input, index bit 2.
- in3  output  1  circuit input, index bit 1.
- in4  output  1  circuit input, index bit 0.
- busy  output  1  sweep in progress.
- done  output  1  one-cycle pulse at sweep end.
- pass  output  1  last sweep had zero mismatches; held until next start.
- mismatch_count  output  5  mismatches in last sweep, range 0..16.
- first_fail_idx  output  4  lowest failing index; 0 when mismatch_count==0.
- resp  output  16  captured synchronized response, bit i for index i.

Behaviour:
- Reset (async assert, sync deassert via clk): state=IDLE.
  - All outputs 0: in1..in4, busy, done, pass, mismatch_count, first_fail_idx, resp.
  - idx=0, cnt=0, synchronizer flops=0.
- Reset mid-sweep aborts immediately: in* drop to 0 and results are cleared. No done pulse.
- States: IDLE, RUN, DONE.
- IDLE:
  - in* = 0.
  - start=1 at an edge → RUN, with idx=0, cnt=0, and mismatch_count, resp, first_fail_idx, pass all cleared.
- RUN:
  - busy=1; {in1,in2,in3,in4} = idx, registered.
  - Each edge with cnt<SETTLE-1: cnt++.
  - Edge with cnt==SETTLE-1:
    - resp[idx] <= sync_out.
    - If sync_out != TT[idx]: mismatch_count++; if this is the first mismatch of the sweep, first_fail_idx <= idx.
    - If idx==15 → DONE; else idx++, cnt=0.
  - Each vector is held exactly SETTLE cycles.
  - Done asserts 16*SETTLE+1 cycles after the start-accepting edge.
- DONE:
  - Lasts one cycle: done=1, busy=0, pass=(mismatch_count==0), in* = 0.
  - Then → IDLE.
- start is ignored in RUN and DONE; it is not queued.
- start held high continuously: a new sweep starts on the first IDLE cycle after DONE.
- sync_out = dut_out delayed through 2 flops. Compare uses the synchronized value only.
- mismatch_count saturation is not needed (max 16 fits in 5 bits).

Optional Feature:
- Macro: TRUTH_TABLE_STABILITY_CHECK_EN.
- Defined:
  - In RUN, track whether sync_out changed during the last STABLE_WIN cycles of each vector's window (cnt >= SETTLE-STABLE_WIN).
  - An unstable vector counts as a mismatch even if the final sample equals TT[idx]. resp still records the final sample.
- Undefined: only the final sample is compared; no stability tracking logic is present.

Test Plan:
- Ideal model (out = TT[{in1..in4}], zero delay), SETTLE=4, start pulse → done after 65 cycles, pass=1, mismatch_count=0, resp=16'h3812, first_fail_idx=0.
- dut_out stuck at 0 → mismatch_count=5, first_fail_idx=1, resp=16'h0000, pass=0. Stuck at 1 → mismatch_count=11, first_fail_idx=0, resp=16'hFFFF.
- Model with 3-cycle output delay: SETTLE=4 → pass=0 with mismatch_count>0. SETTLE=6 → pass=1, resp=16'h3812.
- rst_n low during vector 7 → all outputs 0 asynchronously. Release, then start → full clean sweep with pass=1.
- start pulsed while busy → no restart, done still at cycle 65. start held high → back-to-back sweeps with one IDLE cycle between done pulses.
- With TRUTH_TABLE_STABILITY_CHECK_EN:
  - Model toggles out during the last 2 cycles of vector 4, settling to the correct value → mismatch_count=1, first_fail_idx=4, resp=16'h3812.
  - Same stimulus without the macro → pass=1.
